// File: rtl/muldiv_sched_if.sv
// -----------------------------------------------------------------------------
// muldiv_sched_if
//   Bundles every non-clock signal of the two-hart mul/div scheduler so the
//   scheduler and its environment connect through a single port.
//
//   Request side (per hart h, h = 0/1):
//     req_valid[h], req_ready[h], req_op[3h+:3], req_a/req_b[32h+:32],
//     req_rd[5h+:5], flush[h]
//   Shared muldiv unit side:
//     md_start, md_op, md_a, md_b, md_hart_id  (scheduler -> unit)
//     md_busy, md_done, md_result              (unit -> scheduler)
//   Writeback side:
//     resp_valid[1:0], resp_rd, resp_data, err
//
//   Modports:
//     slave  - the scheduler's view
//     master - the environment's view (harts + muldiv unit + writeback)
// -----------------------------------------------------------------------------
interface muldiv_sched_if;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [5:0]  req_op;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [9:0]  req_rd;
  logic [1:0]  flush;

  logic        md_start;
  logic [2:0]  md_op;
  logic [31:0] md_a;
  logic [31:0] md_b;
  logic        md_hart_id;
  logic        md_busy;
  logic        md_done;
  logic [31:0] md_result;

  logic [1:0]  resp_valid;
  logic [4:0]  resp_rd;
  logic [31:0] resp_data;
  logic        err;

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_rd, flush,
    input  md_busy, md_done, md_result,
    output req_ready,
    output md_start, md_op, md_a, md_b, md_hart_id,
    output resp_valid, resp_rd, resp_data, err
  );

  modport master (
    output req_valid, req_op, req_a, req_b, req_rd, flush,
    output md_busy, md_done, md_result,
    input  req_ready,
    input  md_start, md_op, md_a, md_b, md_hart_id,
    input  resp_valid, resp_rd, resp_data, err
  );
endinterface

// File: rtl/muldiv_sched.sv
// -----------------------------------------------------------------------------
// muldiv_sched
//   Shares one multi-cycle mul/div unit between two harts. Each hart owns a
//   one-entry request slot; a two-state FSM (IDLE/WAIT) grants one slot at a
//   time to the unit, waits for md_done and writes the result back to the
//   owning hart. Flushes drop idle slots immediately and mark the in-flight
//   slot as killed so its result is silently discarded.
//
//   Ports:
//     clk    - system clock, rising edge
//     rst_n  - asynchronous active-low reset
//     bus    - muldiv_sched_if.slave (request, muldiv unit and writeback signals)
//
//   Configuration:
//     MULDIV_SCHED_RR_EN - when defined, round-robin arbitration between the
//                          harts; otherwise hart0 has fixed priority.
// -----------------------------------------------------------------------------
module muldiv_sched (
  input  logic           clk,
  input  logic           rst_n,
  muldiv_sched_if.slave  bus
);

  typedef enum logic {
    IDLE,
    WAIT
  } state_t;

  state_t state;

  // Per-hart request slots.
  logic [1:0]       slot_valid;
  logic [1:0]       slot_kill;
  logic [1:0][2:0]  slot_op;
  logic [1:0][31:0] slot_a;
  logic [1:0][31:0] slot_b;
  logic [1:0][4:0]  slot_rd;

`ifdef MULDIV_SCHED_RR_EN
  // Hart that received the most recent grant.
  logic last_grant;
`endif

  logic [1:0]  accept;
  logic [1:0]  cand;
  logic        grant_hart;
  logic        do_grant;
  logic [2:0]  grant_op;
  logic [31:0] grant_a;
  logic [31:0] grant_b;
  logic        owner;
  logic        resp_kill;

  // A slot can take a new request only when empty, and a flush always wins
  // over a simultaneous request.
  assign bus.req_ready = ~slot_valid & ~bus.flush;
  assign accept        = bus.req_valid & bus.req_ready;

  // A request arriving this cycle competes for the unit alongside the
  // already-held slots, giving a one-cycle request-to-start latency. Slots
  // being flushed this cycle are not eligible.
  assign cand = (slot_valid & ~bus.flush) | accept;

  // The granted hart is remembered in md_hart_id for the whole operation.
  assign owner = bus.md_hart_id;

  // Result is discarded if the owner was flushed earlier or is flushed on
  // the completion edge itself.
  assign resp_kill = slot_kill[owner] | bus.flush[owner];

  assign do_grant = (state == IDLE) && (cand != 2'b00) && !bus.md_busy;

  // Arbitration: single candidate wins outright; a tie is resolved by the
  // configured policy.
  always_comb begin
    grant_hart = cand[1];
    if (cand == 2'b11) begin
`ifdef MULDIV_SCHED_RR_EN
      grant_hart = ~last_grant;
`else
      grant_hart = 1'b0;
`endif
    end
  end

  // Operands come straight from the request bus when the winner is being
  // accepted this same cycle, otherwise from its slot.
  always_comb begin
    grant_op = slot_op[0];
    grant_a  = slot_a[0];
    grant_b  = slot_b[0];
    if (grant_hart) begin
      if (accept[1]) begin
        grant_op = bus.req_op[5:3];
        grant_a  = bus.req_a[63:32];
        grant_b  = bus.req_b[63:32];
      end else begin
        grant_op = slot_op[1];
        grant_a  = slot_a[1];
        grant_b  = slot_b[1];
      end
    end else if (accept[0]) begin
      grant_op = bus.req_op[2:0];
      grant_a  = bus.req_a[31:0];
      grant_b  = bus.req_b[31:0];
    end
  end

  // Slot bookkeeping and the IDLE/WAIT issue FSM. The completion clear in
  // WAIT is written after the per-hart slot updates so it takes precedence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      slot_valid     <= '0;
      slot_kill      <= '0;
      slot_op        <= '0;
      slot_a         <= '0;
      slot_b         <= '0;
      slot_rd        <= '0;
      bus.md_start   <= 1'b0;
      bus.md_op      <= '0;
      bus.md_a       <= '0;
      bus.md_b       <= '0;
      bus.md_hart_id <= 1'b0;
      bus.resp_valid <= '0;
      bus.resp_rd    <= '0;
      bus.resp_data  <= '0;
      bus.err        <= 1'b0;
`ifdef MULDIV_SCHED_RR_EN
      last_grant     <= 1'b1;
`endif
    end else begin
      bus.md_start   <= 1'b0;
      bus.resp_valid <= 2'b00;

      for (int h = 0; h < 2; h++) begin
        if (bus.flush[h]) begin
          // The in-flight slot cannot be recalled from the unit, so it is
          // only marked killed and released at completion.
          if (state == WAIT && owner == h[0]) begin
            slot_kill[h] <= 1'b1;
          end else begin
            slot_valid[h] <= 1'b0;
            slot_kill[h]  <= 1'b0;
          end
        end else if (accept[h]) begin
          slot_valid[h] <= 1'b1;
          slot_kill[h]  <= 1'b0;
          slot_op[h]    <= bus.req_op[h*3 +: 3];
          slot_a[h]     <= bus.req_a[h*32 +: 32];
          slot_b[h]     <= bus.req_b[h*32 +: 32];
          slot_rd[h]    <= bus.req_rd[h*5 +: 5];
        end
      end

      case (state)
        IDLE: begin
          // Nothing is outstanding, so a completion here is stray (e.g. a
          // result from an operation cut short by reset).
          if (bus.md_done) begin
            bus.err <= 1'b1;
          end
          if (do_grant) begin
            bus.md_start   <= 1'b1;
            bus.md_op      <= grant_op;
            bus.md_a       <= grant_a;
            bus.md_b       <= grant_b;
            bus.md_hart_id <= grant_hart;
`ifdef MULDIV_SCHED_RR_EN
            last_grant     <= grant_hart;
`endif
            state          <= WAIT;
          end
        end

        WAIT: begin
          if (bus.md_done) begin
            slot_valid[owner] <= 1'b0;
            slot_kill[owner]  <= 1'b0;
            if (!resp_kill) begin
              bus.resp_valid <= owner ? 2'b10 : 2'b01;
              bus.resp_rd    <= slot_rd[owner];
              bus.resp_data  <= bus.md_result;
            end
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/muldiv_sched.md
MULDIV_SCHED -- requirements
Module: muldiv_sched

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst_n  input  1  reset, asynchronous and active-low.
REQ-003 req_valid  input  2  per-hart mul/div request; bit h = hart h.
REQ-004 req_ready  output  2  per-hart slot free; high when slot h empty and flush[h] low.
REQ-005 req_op  input  6  3-bit op per hart; [2:0] = hart0, [5:3] = hart1.
REQ-006 req_a, req_b  input  64 each  32-bit operands per hart; [31:0] = hart0.
REQ-007 req_rd  input  10  5-bit destination register per hart.
REQ-008 flush  input  2  per-hart kill (trap/redirect).
REQ-009 md_start  output  1  one-cycle start pulse to the shared muldiv unit.
REQ-010 md_op, md_a, md_b, md_hart_id  output  3/32/32/1  operands of the granted request, held from the start cycle until md_done.
REQ-011 md_busy  input  1  unit busy; no start is issued while high.
REQ-012 md_done, md_result  input  1/32  completion pulse and result.
REQ-013 resp_valid  output  2  one-cycle writeback pulse per hart.
REQ-014 resp_rd, resp_data  output  5/32  writeback register and value; shared by both harts.
REQ-015 err  output  1  sticky protocol error.

Function
REQ-016 Each hart has a one-entry slot (valid, op, a, b, rd, kill); req_valid[h] & req_ready[h] loads slot h on the edge.
REQ-017 FSM states are IDLE, WAIT.
REQ-018 IDLE: any slot valid & !md_busy -> grant one hart, register md_start=1 with its operands and md_hart_id, go to WAIT; md_start is high the cycle after the slot loads (1-cycle issue latency).
REQ-019 md_start is high for exactly one cycle per grant; at most one request is in flight.
REQ-020 WAIT: on md_done -> clear the granted slot and go to IDLE; unless the slot's kill bit is set, register resp_valid[owner]=1, resp_rd=slot rd, resp_data=md_result for the next cycle.
REQ-021 The granted slot stays occupied (req_ready low) until md_done; a new request for that hart is accepted no earlier than the cycle resp_valid is high.
REQ-022 flush[h] on an idle (non-granted) slot clears it the same edge; flush[h] on the in-flight slot sets kill, so the response is suppressed and the slot is cleared at md_done.
REQ-023 flush[h] and req_valid[h] in the same cycle: the flush wins and the request is not accepted.
REQ-024 md_done in IDLE is ignored and sets err; md_done with md_hart_id mismatch is impossible by construction.
REQ-025 Completion and a new grant never occur in the same cycle; the earliest re-issue is the cycle after resp_valid.

Reset
REQ-026 Asynchronous reset forces IDLE, clears both slots and kill bits, and sets md_start=0, resp_valid=0, err=0, md_op/a/b/hart_id=0, resp_rd=0, resp_data=0, and the RR pointer to hart1 (so hart0 wins first).
REQ-027 A result arriving after a reset taken mid-operation is dropped per REQ-024.

Configuration
REQ-028 With MULDIV_SCHED_RR_EN defined: round-robin arbitration; with both slots valid, grant the hart other than the last granted, and update the pointer on every grant.
REQ-029 Without MULDIV_SCHED_RR_EN: fixed priority, where hart0 always wins when both are valid; the pointer logic is absent.

Verification
REQ-030 Hart0 req mul a=10 b=3 rd=3 -> md_start the next cycle with op=mul, md_hart_id=0; after md_done with result=30, resp_valid=2'b01, rd=3, data=30 for one cycle.
REQ-031 Both harts request in the same cycle, with RR_EN -> grants hart0, hart1, hart0 for back-to-back requests; without RR_EN, hart0 starves hart1 while it keeps requesting.
REQ-032 md_busy held high for 5 cycles while a slot is valid -> no md_start until the cycle after md_busy falls.
REQ-033 Flush hart1 while its div is in flight -> md_done produces no resp_valid[1], and req_ready[1] rises the cycle after done.
REQ-034 Flush + req_valid on hart0 in the same cycle -> request not accepted, slot stays empty, no md_start.
REQ-035 Assert rst_n low during WAIT, then md_done arrives after release -> no resp_valid, err=1, FSM stays in IDLE.
